ram_read_checker: RTL
=====================

Name: ram_read_checker

Overview:
Reader/checker for the on-chip test RAM's read port (port B). On start, it reads DEPTH words and compares each against the expected incrementing pattern the RAM pattern writer stores (SEED at address 0, +1 per address). It reports pass/fail, the error count and the first failing address and data. It sits beside the RAM instance, and its status outputs are intended for ILA probes.

Parameters:
ADDR_W, 9, RAM address width
DATA_W, 16, RAM data width
DEPTH, 512, number of words checked (1..2^ADDR_W)
SEED, 1, expected data at address 0
RD_LAT, 1, RAM read latency in cycles from address to data (1..3)
ERR_W, 10, error counter width

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse that begins a check run; ignored while busy
rd_en  out  1  RAM port-B enable
rd_addr  out  ADDR_W  RAM port-B address
rd_data  in  DATA_W  RAM port-B data, valid RD_LAT cycles after rd_addr/rd_en
busy  out  1  run in progress
done  out  1  one-cycle pulse when a run completes
pass  out  1  latched result: 1 when the last run had zero mismatches
err_cnt  out  ERR_W  mismatch count of the last or current run; saturates at all-ones
first_err_addr  out  ADDR_W  address of the first mismatch
first_err_data  out  DATA_W  data read at the first mismatch

Behaviour:
- Reset: state IDLE. rd_en=0, rd_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, first_err_data=0. The delay line is cleared.
- Reset mid-run: the run aborts immediately and all outputs return to reset values. No done pulse is generated.
- IDLE: when start=1, clear err_cnt, the first-error registers and pass, then go to READ. busy=1 from the next cycle.
- READ: rd_en=1. rd_addr starts at 0 and increments by 1 each cycle up to DEPTH-1. After issuing address DEPTH-1, go to DRAIN.
- Delay line: valid/address/expected registers RD_LAT stages deep, aligned with rd_data.
  - The expected value is (SEED + addr) modulo 2^DATA_W; it wraps silently.
- Compare: for each valid stage output, a mismatch occurs when rd_data differs from expected.
  - On mismatch, err_cnt increments, saturating at 2^ERR_W-1.
  - On the first mismatch of a run, capture first_err_addr and first_err_data. Later mismatches do not overwrite them.
- DRAIN: rd_en=0. Wait exactly RD_LAT cycles for in-flight reads, then go to DONE.
- DONE: a single cycle. done=1, busy=0, pass=(err_cnt==0), including the final compare. Then go to IDLE.
- start while busy: ignored, not queued.
- start in the DONE cycle: ignored.
- Latency: start to done is DEPTH + RD_LAT + 2 cycles.
- DEPTH=1: READ lasts one cycle.
- rd_addr holds its last value after the run. Results hold until the next start or reset.

Optional Feature:
STOP_ON_ERR_EN
- Defined: on the first mismatch, READ stops issuing addresses and moves to DRAIN. err_cnt ends at 1 plus any in-flight mismatches (at most RD_LAT in total).
- Undefined: all DEPTH words are always read and counted.

Decomposition:
- Package ram_chk_pkg: state enum (IDLE, READ, DRAIN, DONE) and default width constants.
- One sub-module, ram_chk_delay: a parameterized RD_LAT-stage pipeline carrying valid, addr and expected, with synchronous clear on rst.
- The FSM, comparator and counters stay in ram_read_checker.

Test Plan:
- Model RAM preloaded with 1..512, RD_LAT=1, single start pulse -> done after 515 cycles, pass=1, err_cnt=0, 512 rd_en cycles, addresses 0..511.
- Word 100 corrupted to 16'hDEAD -> pass=0, err_cnt=1, first_err_addr=100, first_err_data=16'hDEAD.
- Words 7, 8 and 300 corrupted, RD_LAT=2 -> err_cnt=3, first_err_addr=7, done after 516 cycles.
- SEED=16'hFFFF, DEPTH=4, RAM holds FFFF,0000,0001,0002 -> pass=1, confirming the wrap.
- start re-pulsed at cycle 50 of a run, then rst asserted at cycle 200 -> second start ignored. On rst: busy=0, err_cnt=0, no done pulse. A fresh start afterwards completes normally.
- STOP_ON_ERR_EN defined, word 10 corrupted, RD_LAT=1 -> last rd_addr issued is 11, err_cnt=1, done pulse, pass=0.

Source files
------------

// File: rtl/ram_chk_pkg.sv
// Shared types and default sizing for the test-RAM read checker.
package ram_chk_pkg;

  localparam int unsigned CHK_ADDR_W = 9;
  localparam int unsigned CHK_DATA_W = 16;
  localparam int unsigned CHK_DEPTH  = 512;
  localparam int unsigned CHK_SEED   = 1;
  localparam int unsigned CHK_RD_LAT = 1;
  localparam int unsigned CHK_ERR_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/ram_chk_delay.sv
// RD_LAT-stage pipeline that carries valid/address/expected alongside the
// RAM read so they line up with rd_data.
module ram_chk_delay
  import ram_chk_pkg::*;
#(
  parameter int unsigned ADDR_W = CHK_ADDR_W,
  parameter int unsigned DATA_W = CHK_DATA_W,
  parameter int unsigned RD_LAT = CHK_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);

  logic              valid_q [RD_LAT];
  logic [ADDR_W-1:0] addr_q  [RD_LAT];
  logic [DATA_W-1:0] exp_q   [RD_LAT];

  // Shift register; stage 0 captures the issued read, the last stage aligns with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        exp_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      exp_q[0]   <= in_exp;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];
  assign out_exp   = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_read_checker.sv
// Test-RAM port-B reader/checker: reads DEPTH words, compares them against the
// incrementing pattern (SEED + addr) and latches pass, error count and the
// first failing address/data.
// Optional build macro STOP_ON_ERR_EN: stop issuing reads at the first mismatch.
module ram_read_checker
  import ram_chk_pkg::*;
#(
  parameter int unsigned ADDR_W = CHK_ADDR_W,
  parameter int unsigned DATA_W = CHK_DATA_W,
  parameter int unsigned DEPTH  = CHK_DEPTH,
  parameter int unsigned SEED   = CHK_SEED,
  parameter int unsigned RD_LAT = CHK_RD_LAT,
  parameter int unsigned ERR_W  = CHK_ERR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  chk_state_e        state;
  logic [1:0]        drain_cnt;
  logic [DATA_W-1:0] exp_c;
  logic              dl_valid;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_exp;
  logic              mismatch_c;
  logic              stop_c;

  // Expected word for the address being issued; wraps modulo 2^DATA_W.
  assign exp_c = DATA_W'(SEED) + DATA_W'(rd_addr);

  ram_chk_delay #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_addr   (rd_addr),
    .in_exp    (exp_c),
    .out_valid (dl_valid),
    .out_addr  (dl_addr),
    .out_exp   (dl_exp)
  );

  assign mismatch_c = dl_valid && (rd_data != dl_exp);

`ifdef STOP_ON_ERR_EN
  assign stop_c = mismatch_c;
`else
  assign stop_c = 1'b0;
`endif

  // Run FSM, error counter and first-error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      done <= 1'b0;

      if (mismatch_c) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
        if (err_cnt == '0) begin
          first_err_addr <= dl_addr;
          first_err_data <= rd_data;
        end
      end

      case (state)
        IDLE: begin
          // done is high only in the cycle after DONE; a start there is dropped
          if (start && !done) begin
            state          <= READ;
            rd_en          <= 1'b1;
            rd_addr        <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
          end
        end
        READ: begin
          if ((rd_addr == LAST_ADDR) || stop_c) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_cnt == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
